rf_write_arbiter: RTL and testbench
===================================

Name: rf_write_arbiter

Overview:
- Shares the single write port of the 8-entry x 8-bit register file between two writeback sources: requester 0 (ALU) and requester 1 (load unit).
- Arbitrates round-robin and registers the winning write onto the register file's write_enable/write_reg/write_data inputs.
- Exposes the in-flight write for forwarding, so the core can bypass data not yet committed.

Parameters:
- DATA_W, 8, width of write data.
- ADDR_W, 3, width of register index (2^ADDR_W registers).

Ports:
- clk  input  1  clock; all state updates on rising edge.
- rst_n  input  1  synchronous active-low reset, sampled on rising edge of clk.
- stall  input  1  when 1, no grant is issued this cycle.
- req0_valid  input  1  requester 0 has a write.
- req0_addr  input  ADDR_W  requester 0 destination register.
- req0_data  input  DATA_W  requester 0 write data.
- req0_ready  output  1  requester 0 write accepted this cycle (combinational).
- req1_valid  input  1  requester 1 has a write.
- req1_addr  input  ADDR_W  requester 1 destination register.
- req1_data  input  DATA_W  requester 1 write data.
- req1_ready  output  1  requester 1 write accepted this cycle (combinational).
- rf_we  output  1  register-file write enable (registered).
- rf_waddr  output  ADDR_W  register-file write index (registered).
- rf_wdata  output  DATA_W  register-file write data (registered).
- last_grant  output  1  index of the most recently granted requester.
- conflict  output  1  registered pulse; both requesters were valid with equal addr in the arbitrated cycle.

Behaviour:
- Reset (rst_n=0 at a clk edge): rf_we=0, rf_waddr=0, rf_wdata=0, last_grant=1 (so requester 0 wins the first tie), conflict=0.
  - While rst_n=0, req0_ready=req1_ready=0 combinationally.
  - A write accepted in the cycle before reset is lost if reset is sampled on the edge where it would register. Requesters must reissue after reset.
- Handshake: transfer occurs when reqN_valid && reqN_ready.
  - A requester must hold valid, addr and data stable until ready.
  - ready never depends on a future cycle.
- Grant (combinational, evaluated each cycle):
  - stall=1 or rst_n=0: no grant.
  - Only one requester valid: that requester is granted.
  - Both valid: the requester other than last_grant is granted (round-robin).
  - At most one ready is high per cycle.
- Registered stage: on the clk edge after a grant, rf_we=1, rf_waddr/rf_wdata take the granted addr/data, and last_grant takes the granted index.
  - With no grant: rf_we=0; rf_waddr/rf_wdata hold their previous values; last_grant holds.
- Latency: data is accepted in cycle N, presented to the register file in cycle N+1, and visible on register-file reads in cycle N+2.
- Throughput: one write per cycle. Back-to-back grants are allowed; rf_we stays high continuously.
- Starvation bound: with both requesters continuously valid and stall=0, each is granted every 2 cycles.
- Same-address collision: both valid with equal addr.
  - The arbitration winner writes first; the loser writes in a later cycle, so the loser's value is final.
  - conflict=1 for exactly the cycle rf_we reflects the winner.
- stall held high: requesters stay pending and ready=0. The registered stage still drains, so rf_we drops to 0 one cycle after stall rises.
- Forwarding: rf_we/rf_waddr/rf_wdata are the forwarding source for the in-flight write. No separate forward port is provided.
- No hardwired-zero register: writes to index 0 are performed normally.

Test Plan:
- Reset then idle: rst_n=0 for 2 cycles, then 1, all valids 0 -> rf_we=0, rf_waddr=0, rf_wdata=0, last_grant=1, both ready=0 throughout.
- Single writes: req0 (addr=3, data=0xA5) for 1 cycle -> req0_ready=1 that cycle; next cycle rf_we=1, rf_waddr=3, rf_wdata=0xA5, last_grant=0. Repeat on req1 (addr=7, data=0x3C) -> same pattern, last_grant=1.
- Round-robin under contention: both valid for 4 cycles with distinct addrs after reset -> grants 0,1,0,1; rf_we high 4 consecutive cycles starting 1 cycle after the first grant.
- Collision: both valid, addr=5, req0 data=0x11, req1 data=0x22, last_grant=1 -> rf_wdata=0x11 then 0x22 on successive cycles; conflict=1 only in the first; register 5 ends at 0x22.
- Stall: both valid, stall=1 for 3 cycles -> both ready=0 and rf_we=0 after one drain cycle; on stall=0, grants resume per last_grant.
- Reset mid-operation: grant req1 (addr=2, data=0xFF) in cycle N, rst_n=0 sampled at the edge ending N -> rf_we=0 in N+1 and register 2 unchanged.

Source files
------------

// File: rtl/rf_write_arbiter.sv
// Round-robin arbiter that shares the single register-file write port between the ALU (req0)
// and the load unit (req1). The registered write doubles as the forwarding source.
module rf_write_arbiter #(
    parameter int DATA_W = 8,
    parameter int ADDR_W = 3
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              stall,
    input  logic              req0_valid,
    input  logic [ADDR_W-1:0] req0_addr,
    input  logic [DATA_W-1:0] req0_data,
    output logic              req0_ready,
    input  logic              req1_valid,
    input  logic [ADDR_W-1:0] req1_addr,
    input  logic [DATA_W-1:0] req1_data,
    output logic              req1_ready,
    output logic              rf_we,
    output logic [ADDR_W-1:0] rf_waddr,
    output logic [DATA_W-1:0] rf_wdata,
    output logic              last_grant,
    output logic              conflict
);

    logic              r_we;
    logic [ADDR_W-1:0] r_waddr;
    logic [DATA_W-1:0] r_wdata;
    logic              r_last_grant;
    logic              r_conflict;

    logic              w_open;
    logic              w_grant0;
    logic              w_grant1;
    logic              w_any_grant;
    logic              w_same_addr;

    // Ties go to the requester that did not win last time.
    assign w_open      = rst_n && !stall;
    assign w_grant0    = w_open && req0_valid && (!req1_valid || r_last_grant);
    assign w_grant1    = w_open && req1_valid && (!req0_valid || !r_last_grant);
    assign w_any_grant = w_grant0 || w_grant1;
    assign w_same_addr = req0_valid && req1_valid && (req0_addr == req1_addr);

    assign req0_ready = w_grant0;
    assign req1_ready = w_grant1;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_we         <= 1'b0;
            r_waddr      <= '0;
            r_wdata      <= '0;
            r_last_grant <= 1'b1;
            r_conflict   <= 1'b0;
        end else begin
            r_we       <= w_any_grant;
            r_conflict <= w_any_grant && w_same_addr;
            if (w_any_grant) begin
                r_waddr      <= w_grant1 ? req1_addr : req0_addr;
                r_wdata      <= w_grant1 ? req1_data : req0_data;
                r_last_grant <= w_grant1;
            end
        end
    end

    assign rf_we      = r_we;
    assign rf_waddr   = r_waddr;
    assign rf_wdata   = r_wdata;
    assign last_grant = r_last_grant;
    assign conflict   = r_conflict;

endmodule

// File: tb/tb_rf_write_arbiter.sv
// Bench for rf_write_arbiter: directed vector table, hand sequences for reset corner cases,
// then randomized traffic against a transaction-level reference model.
module tb_rf_write_arbiter;

    logic       clk;
    logic       rst_n;
    logic       stall;
    logic       req0_valid;
    logic [2:0] req0_addr;
    logic [7:0] req0_data;
    logic       req0_ready;
    logic       req1_valid;
    logic [2:0] req1_addr;
    logic [7:0] req1_data;
    logic       req1_ready;
    logic       rf_we;
    logic [2:0] rf_waddr;
    logic [7:0] rf_wdata;
    logic       last_grant;
    logic       conflict;

    int errors = 0;
    int checks = 0;

    rf_write_arbiter #(.DATA_W(8), .ADDR_W(3)) dut (
        .clk(clk), .rst_n(rst_n), .stall(stall),
        .req0_valid(req0_valid), .req0_addr(req0_addr), .req0_data(req0_data), .req0_ready(req0_ready),
        .req1_valid(req1_valid), .req1_addr(req1_addr), .req1_data(req1_data), .req1_ready(req1_ready),
        .rf_we(rf_we), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata),
        .last_grant(last_grant), .conflict(conflict)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // The register file this arbiter feeds.
    logic [7:0] rf_mem [8];
    always @(posedge clk) if (rf_we) rf_mem[rf_waddr] <= rf_wdata;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    typedef struct {
        logic       rst_n, stall;
        logic       v0; logic [2:0] a0; logic [7:0] d0;
        logic       v1; logic [2:0] a1; logic [7:0] d1;
        logic       r0, r1, we;
        logic [2:0] wa; logic [7:0] wd;
        logic       lg, cf;
    } vec_t;

    function automatic vec_t mk(logic rs, logic st, logic v0, logic [2:0] a0, logic [7:0] d0,
                                logic v1, logic [2:0] a1, logic [7:0] d1, logic r0, logic r1,
                                logic we, logic [2:0] wa, logic [7:0] wd, logic lg, logic cf);
        vec_t v;
        v.rst_n = rs; v.stall = st;
        v.v0 = v0; v.a0 = a0; v.d0 = d0;
        v.v1 = v1; v.a1 = a1; v.d1 = d1;
        v.r0 = r0; v.r1 = r1; v.we = we; v.wa = wa; v.wd = wd; v.lg = lg; v.cf = cf;
        return v;
    endfunction

    task automatic drive(input logic rs, input logic st, input logic v0, input logic [2:0] a0,
                         input logic [7:0] d0, input logic v1, input logic [2:0] a1, input logic [7:0] d1);
        rst_n = rs; stall = st;
        req0_valid = v0; req0_addr = a0; req0_data = d0;
        req1_valid = v1; req1_addr = a1; req1_data = d1;
    endtask

    vec_t vt[22];

    // Reference model state (transaction level).
    logic       p0, p1;
    logic [2:0] pa0, pa1;
    logic [7:0] pd0, pd1;
    logic       m_we, m_lg, m_cf;
    logic [2:0] m_wa;
    logic [7:0] m_wd;

    initial begin
        drive(0, 0, 0, 0, 0, 0, 0, 0);

        //        rs st v0 a0 d0     v1 a1 d1     r0 r1 we wa wd     lg cf
        vt[0]  = mk(0, 0, 0, 0, 8'h00, 0, 0, 8'h00, 0, 0, 0, 0, 8'h00, 1, 0);
        vt[1]  = mk(0, 0, 0, 0, 8'h00, 0, 0, 8'h00, 0, 0, 0, 0, 8'h00, 1, 0);
        vt[2]  = mk(1, 0, 0, 0, 8'h00, 0, 0, 8'h00, 0, 0, 0, 0, 8'h00, 1, 0);
        vt[3]  = mk(1, 0, 1, 3, 8'hA5, 0, 0, 8'h00, 1, 0, 1, 3, 8'hA5, 0, 0);
        vt[4]  = mk(1, 0, 0, 0, 8'h00, 0, 0, 8'h00, 0, 0, 0, 3, 8'hA5, 0, 0);
        vt[5]  = mk(1, 0, 0, 0, 8'h00, 1, 7, 8'h3C, 0, 1, 1, 7, 8'h3C, 1, 0);
        vt[6]  = mk(1, 0, 0, 0, 8'h00, 0, 0, 8'h00, 0, 0, 0, 7, 8'h3C, 1, 0);
        vt[7]  = mk(1, 0, 1, 1, 8'h10, 1, 2, 8'h20, 1, 0, 1, 1, 8'h10, 0, 0);
        vt[8]  = mk(1, 0, 1, 3, 8'h30, 1, 2, 8'h20, 0, 1, 1, 2, 8'h20, 1, 0);
        vt[9]  = mk(1, 0, 1, 3, 8'h30, 1, 4, 8'h40, 1, 0, 1, 3, 8'h30, 0, 0);
        vt[10] = mk(1, 0, 0, 0, 8'h00, 1, 4, 8'h40, 0, 1, 1, 4, 8'h40, 1, 0);
        vt[11] = mk(1, 0, 0, 0, 8'h00, 0, 0, 8'h00, 0, 0, 0, 4, 8'h40, 1, 0);
        vt[12] = mk(1, 0, 1, 5, 8'h11, 1, 5, 8'h22, 1, 0, 1, 5, 8'h11, 0, 1);
        vt[13] = mk(1, 0, 0, 0, 8'h00, 1, 5, 8'h22, 0, 1, 1, 5, 8'h22, 1, 0);
        vt[14] = mk(1, 0, 0, 0, 8'h00, 0, 0, 8'h00, 0, 0, 0, 5, 8'h22, 1, 0);
        vt[15] = mk(1, 0, 1, 6, 8'h66, 0, 0, 8'h00, 1, 0, 1, 6, 8'h66, 0, 0);
        vt[16] = mk(1, 1, 1, 1, 8'h01, 1, 2, 8'h02, 0, 0, 0, 6, 8'h66, 0, 0);
        vt[17] = mk(1, 1, 1, 1, 8'h01, 1, 2, 8'h02, 0, 0, 0, 6, 8'h66, 0, 0);
        vt[18] = mk(1, 1, 1, 1, 8'h01, 1, 2, 8'h02, 0, 0, 0, 6, 8'h66, 0, 0);
        vt[19] = mk(1, 0, 1, 1, 8'h01, 1, 2, 8'h02, 0, 1, 1, 2, 8'h02, 1, 0);
        vt[20] = mk(1, 0, 1, 1, 8'h01, 0, 0, 8'h00, 1, 0, 1, 1, 8'h01, 0, 0);
        vt[21] = mk(1, 0, 0, 0, 8'h00, 0, 0, 8'h00, 0, 0, 0, 1, 8'h01, 0, 0);

        @(posedge clk); #1;
        for (int i = 0; i < 22; i++) begin
            drive(vt[i].rst_n, vt[i].stall, vt[i].v0, vt[i].a0, vt[i].d0, vt[i].v1, vt[i].a1, vt[i].d1);
            @(negedge clk);
            chk($sformatf("v%0d req0_ready", i), req0_ready, vt[i].r0);
            chk($sformatf("v%0d req1_ready", i), req1_ready, vt[i].r1);
            @(posedge clk); #1;
            chk($sformatf("v%0d rf_we", i), rf_we, vt[i].we);
            chk($sformatf("v%0d rf_waddr", i), rf_waddr, vt[i].wa);
            chk($sformatf("v%0d rf_wdata", i), rf_wdata, vt[i].wd);
            chk($sformatf("v%0d last_grant", i), last_grant, vt[i].lg);
            chk($sformatf("v%0d conflict", i), conflict, vt[i].cf);
        end
        chk("collision reg5 final", rf_mem[5], 8'h22);

        // Grant req1 mid-cycle, then pull reset before the edge that would register it.
        drive(1, 0, 0, 0, 8'h00, 1, 2, 8'hFF);
        @(negedge clk);
        chk("midrst req1_ready", req1_ready, 1'b1);
        rst_n = 1'b0;
        #1;
        chk("midrst ready0 in reset", req0_ready, 1'b0);
        chk("midrst ready1 in reset", req1_ready, 1'b0);
        @(posedge clk); #1;
        chk("midrst rf_we", rf_we, 1'b0);
        chk("midrst last_grant", last_grant, 1'b1);
        drive(1, 0, 0, 0, 8'h00, 0, 0, 8'h00);
        @(posedge clk); #1;
        chk("midrst rf_we idle", rf_we, 1'b0);
        @(posedge clk); #1;
        chk("midrst reg2 unchanged", rf_mem[2], 8'h02);

        // Randomized traffic; requesters hold each write until it is accepted.
        p0 = 0; p1 = 0; pa0 = 0; pa1 = 0; pd0 = 0; pd1 = 0;
        m_we = 0; m_wa = 0; m_wd = 0; m_lg = 1; m_cf = 0;
        for (int i = 0; i < 400; i++) begin
            logic rs, st, e0, e1;
            int g;
            if (!p0 && $urandom_range(0, 99) < 60) begin
                p0 = 1; pa0 = 3'($urandom_range(0, 7)); pd0 = 8'($urandom);
            end
            if (!p1 && $urandom_range(0, 99) < 60) begin
                p1 = 1; pd1 = 8'($urandom);
                pa1 = ($urandom_range(0, 1) == 1) ? pa0 : 3'($urandom_range(0, 7));
            end
            rs = (i < 2) ? 1'b0 : ($urandom_range(0, 99) >= 3);
            st = ($urandom_range(0, 99) < 20);
            drive(rs, st, p0, pa0, pd0, p1, pa1, pd1);

            g = -1;
            if (rs && !st) begin
                if (p0 && p1) g = m_lg ? 0 : 1;
                else if (p0) g = 0;
                else if (p1) g = 1;
            end
            e0 = (g == 0);
            e1 = (g == 1);

            @(negedge clk);
            chk($sformatf("r%0d req0_ready", i), req0_ready, e0);
            chk($sformatf("r%0d req1_ready", i), req1_ready, e1);

            if (!rs) begin
                m_we = 0; m_wa = 0; m_wd = 0; m_lg = 1; m_cf = 0;
            end else if (g >= 0) begin
                m_we = 1;
                m_wa = (g == 1) ? pa1 : pa0;
                m_wd = (g == 1) ? pd1 : pd0;
                m_lg = (g == 1);
                m_cf = p0 && p1 && (pa0 == pa1);
            end else begin
                m_we = 0; m_cf = 0;
            end
            if (e0) p0 = 0;
            if (e1) p1 = 0;

            @(posedge clk); #1;
            chk($sformatf("r%0d rf_we", i), rf_we, m_we);
            chk($sformatf("r%0d rf_waddr", i), rf_waddr, m_wa);
            chk($sformatf("r%0d rf_wdata", i), rf_wdata, m_wd);
            chk($sformatf("r%0d last_grant", i), last_grant, m_lg);
            chk($sformatf("r%0d conflict", i), conflict, m_cf);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
